// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the five-stage pipeline hazard controller:
// bypass-select encodings, operand-use and result-latency widths, default
// multiply/divide busy lengths, and the register-match helper.
// No ports (package).
// ---------------------------------------------------------------------------
package pipe_pkg;

   localparam int REG_W  = 5;
   localparam int TUSE_W = 2;
   localparam int TNEW_W = 2;

   localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

   // D-stage bypass selects: regfile / E result / M result.
   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_E  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;

   // E-stage bypass selects share the 2-bit field but are shifted one stage
   // later: 0 keeps the E register, 1 takes the M result, 2 the W result.
   localparam logic [1:0] FWD_E_REG = 2'd0;
   localparam logic [1:0] FWD_E_M   = 2'd1;
   localparam logic [1:0] FWD_W     = 2'd2;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // $0 is hard-wired, so it can never be a producer worth waiting on.
   function automatic logic reg_match(input logic [REG_W-1:0] src,
                                      input logic [REG_W-1:0] wreg,
                                      input logic             regwrite);
      return (src != '0) && regwrite && (wreg == src);
   endfunction

endpackage

// File: rtl/mdu_busy_tracker.sv
// ---------------------------------------------------------------------------
// mdu_busy_tracker
// Tracks the multiply/divide unit busy window. A start loads the down-counter
// with the operation length (restarting if already busy); it then counts to 0.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   md_start_E      E-stage instruction starts the MDU this cycle
//   md_is_div_E     started operation is a divide
//   md_busy         MDU result not yet available (includes the start cycle)
// ---------------------------------------------------------------------------
module mdu_busy_tracker
   import pipe_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start_E,
   input  logic md_is_div_E,
   output logic md_busy
);

   localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (md_start_E) begin
         cnt_d = md_is_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign md_busy = md_start_E || (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and forwarding controller for the F/D/E/M/W pipeline. Keeps an
// E->M->W shadow of destination fields, derives stalls/E bubbles and the
// D- and E-stage bypass selects, and holds HI/LO consumers while the MDU
// is busy.
// Optional feature macro: HAZARD_PERF_CNT_EN adds the stall_cnt port, a
// free-running count of stalled cycles.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   rs_D, rt_D                  D-stage source registers
//   tuse_rs_D, tuse_rt_D        cycles until operand needed (3 = unused)
//   wreg_D, regwrite_D, tnew_D  D-stage destination, write enable, latency
//   md_use_D                    D-stage instruction uses the MDU / HI / LO
//   md_start_E, md_is_div_E     MDU start and operation kind from E
//   stall_F, stall_D, flush_E   hold PC / hold D / bubble into E
//   fwd_rs_D, fwd_rt_D          D bypass: 0 regfile, 1 E, 2 M
//   fwd_rs_E, fwd_rt_E          E bypass: 0 E reg, 1 M, 2 W
//   md_busy                     MDU result not yet available
//   stall_cnt                   stalled-cycle count (macro build only)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_W-1:0]  rs_D,
   input  logic [REG_W-1:0]  rt_D,
   input  logic [TUSE_W-1:0] tuse_rs_D,
   input  logic [TUSE_W-1:0] tuse_rt_D,
   input  logic [REG_W-1:0]  wreg_D,
   input  logic              regwrite_D,
   input  logic [TNEW_W-1:0] tnew_D,
   input  logic              md_use_D,
   input  logic              md_start_E,
   input  logic              md_is_div_E,
   output logic              stall_F,
   output logic              stall_D,
   output logic              flush_E,
   output logic [1:0]        fwd_rs_D,
   output logic [1:0]        fwd_rt_D,
   output logic [1:0]        fwd_rs_E,
   output logic [1:0]        fwd_rt_E,
   output logic              md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,output logic [31:0]       stall_cnt
`endif
);

   logic [REG_W-1:0]  rs_e_q, rs_e_d, rt_e_q, rt_e_d;
   logic [REG_W-1:0]  wreg_e_q, wreg_e_d, wreg_m_q, wreg_m_d, wreg_w_q, wreg_w_d;
   logic              regwrite_e_q, regwrite_e_d, regwrite_m_q, regwrite_m_d;
   logic              regwrite_w_q, regwrite_w_d;
   logic [TNEW_W-1:0] tnew_e_q, tnew_e_d, tnew_m_q, tnew_m_d;

   logic stall_rs, stall_rt, stall;

   mdu_busy_tracker #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_mdu (
      .clk         (clk),
      .reset       (reset),
      .md_start_E  (md_start_E),
      .md_is_div_E (md_is_div_E),
      .md_busy     (md_busy)
   );

   // A consumer must wait when its producer's result arrives later than
   // the operand is needed. TUSE_NONE exceeds every tnew, so it never stalls.
   assign stall_rs = (reg_match(rs_D, wreg_e_q, regwrite_e_q) && (tuse_rs_D < tnew_e_q))
                  || (reg_match(rs_D, wreg_m_q, regwrite_m_q) && (tuse_rs_D < tnew_m_q));
   assign stall_rt = (reg_match(rt_D, wreg_e_q, regwrite_e_q) && (tuse_rt_D < tnew_e_q))
                  || (reg_match(rt_D, wreg_m_q, regwrite_m_q) && (tuse_rt_D < tnew_m_q));
   assign stall    = stall_rs || stall_rt || (md_use_D && md_busy);

   assign stall_F = stall;
   assign stall_D = stall;
   assign flush_E = stall;

   // W needs no D-stage bypass: the register file writes before it reads.
   always_comb begin
      fwd_rs_D = FWD_RF;
      fwd_rt_D = FWD_RF;
      fwd_rs_E = FWD_E_REG;
      fwd_rt_E = FWD_E_REG;

      if (reg_match(rs_D, wreg_e_q, regwrite_e_q) && (tnew_e_q == '0)) begin
         fwd_rs_D = FWD_E;
      end else if (reg_match(rs_D, wreg_m_q, regwrite_m_q) && (tnew_m_q == '0)) begin
         fwd_rs_D = FWD_M;
      end

      if (reg_match(rt_D, wreg_e_q, regwrite_e_q) && (tnew_e_q == '0)) begin
         fwd_rt_D = FWD_E;
      end else if (reg_match(rt_D, wreg_m_q, regwrite_m_q) && (tnew_m_q == '0)) begin
         fwd_rt_D = FWD_M;
      end

      if (reg_match(rs_e_q, wreg_m_q, regwrite_m_q) && (tnew_m_q == '0)) begin
         fwd_rs_E = FWD_E_M;
      end else if (reg_match(rs_e_q, wreg_w_q, regwrite_w_q)) begin
         fwd_rs_E = FWD_W;
      end

      if (reg_match(rt_e_q, wreg_m_q, regwrite_m_q) && (tnew_m_q == '0)) begin
         fwd_rt_E = FWD_E_M;
      end else if (reg_match(rt_e_q, wreg_w_q, regwrite_w_q)) begin
         fwd_rt_E = FWD_W;
      end
   end

   always_comb begin
      rs_e_d       = rs_D;
      rt_e_d       = rt_D;
      wreg_e_d     = wreg_D;
      regwrite_e_d = regwrite_D;
      tnew_e_d     = tnew_D;
      if (stall) begin
         rs_e_d       = '0;
         rt_e_d       = '0;
         wreg_e_d     = '0;
         regwrite_e_d = 1'b0;
         tnew_e_d     = '0;
      end

      wreg_m_d     = wreg_e_q;
      regwrite_m_d = regwrite_e_q;
      tnew_m_d     = (tnew_e_q == '0) ? '0 : (tnew_e_q - TNEW_W'(1));

      wreg_w_d     = wreg_m_q;
      regwrite_w_d = regwrite_m_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rs_e_q       <= '0;
         rt_e_q       <= '0;
         wreg_e_q     <= '0;
         regwrite_e_q <= 1'b0;
         tnew_e_q     <= '0;
         wreg_m_q     <= '0;
         regwrite_m_q <= 1'b0;
         tnew_m_q     <= '0;
         wreg_w_q     <= '0;
         regwrite_w_q <= 1'b0;
      end else begin
         rs_e_q       <= rs_e_d;
         rt_e_q       <= rt_e_d;
         wreg_e_q     <= wreg_e_d;
         regwrite_e_q <= regwrite_e_d;
         tnew_e_q     <= tnew_e_d;
         wreg_m_q     <= wreg_m_d;
         regwrite_m_q <= regwrite_m_d;
         tnew_m_q     <= tnew_m_d;
         wreg_w_q     <= wreg_w_d;
         regwrite_w_q <= regwrite_w_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Wraps naturally at 2^32.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] rs_D, rt_D, wreg_D;
   logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
   logic       regwrite_D, md_use_D, md_start_E, md_is_div_E;
   logic       stall_F, stall_D, flush_E, md_busy;
   logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .rs_D        (rs_D),
      .rt_D        (rt_D),
      .tuse_rs_D   (tuse_rs_D),
      .tuse_rt_D   (tuse_rt_D),
      .wreg_D      (wreg_D),
      .regwrite_D  (regwrite_D),
      .tnew_D      (tnew_D),
      .md_use_D    (md_use_D),
      .md_start_E  (md_start_E),
      .md_is_div_E (md_is_div_E),
      .stall_F     (stall_F),
      .stall_D     (stall_D),
      .flush_E     (flush_E),
      .fwd_rs_D    (fwd_rs_D),
      .fwd_rt_D    (fwd_rt_D),
      .fwd_rs_E    (fwd_rs_E),
      .fwd_rt_E    (fwd_rt_E),
      .md_busy     (md_busy)
`ifdef HAZARD_PERF_CNT_EN
     ,.stall_cnt   (stall_cnt)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each in-flight instruction carries the absolute cycle
   // at which its result exists; remaining latency is derived from "now".
   typedef struct {
      int rs;
      int rt;
      int wreg;
      bit rw;
      int ready;
   } ins_t;

   ins_t        sl_e, sl_m, sl_w;
   int          now = 0;
   int          busy_until = -1;
   int unsigned m_stall_cnt = 0;

   function automatic int rem(input ins_t s);
      return (s.ready > now) ? (s.ready - now) : 0;
   endfunction

   function automatic bit hit(input ins_t s, input int r);
      return (r != 0) && s.rw && (s.wreg == r);
   endfunction

   function automatic bit m_busy();
      return md_start_E || (now <= busy_until);
   endfunction

   function automatic bit src_stall(input int r, input int tuse);
      return (hit(sl_e, r) && tuse < rem(sl_e)) || (hit(sl_m, r) && tuse < rem(sl_m));
   endfunction

   function automatic bit m_stall();
      return src_stall(int'(rs_D), int'(tuse_rs_D)) || src_stall(int'(rt_D), int'(tuse_rt_D))
          || (md_use_D && m_busy());
   endfunction

   function automatic int m_fwd_d(input int r);
      if (hit(sl_e, r) && rem(sl_e) == 0) return 1;
      if (hit(sl_m, r) && rem(sl_m) == 0) return 2;
      return 0;
   endfunction

   function automatic int m_fwd_e(input int r);
      if (hit(sl_m, r) && rem(sl_m) == 0) return 1;
      if (hit(sl_w, r)) return 2;
      return 0;
   endfunction

   always @(posedge clk) begin
      bit st;
      st = m_stall();
      if (reset) begin
         sl_e = '{default: 0};
         sl_m = '{default: 0};
         sl_w = '{default: 0};
         busy_until  = -1;
         m_stall_cnt = 0;
      end else begin
         if (st) m_stall_cnt++;
         sl_w = sl_m;
         sl_m = sl_e;
         if (st) begin
            sl_e = '{default: 0};
         end else begin
            sl_e.rs    = int'(rs_D);
            sl_e.rt    = int'(rt_D);
            sl_e.wreg  = int'(wreg_D);
            sl_e.rw    = regwrite_D;
            sl_e.ready = now + 1 + int'(tnew_D);
         end
         if (md_start_E) busy_until = now + (md_is_div_E ? 10 : 5);
      end
      now++;
   end

   always @(negedge clk) begin
      bit st;
      if (chk_en && !reset) begin
         st = m_stall();
         chk("stall_F", int'(stall_F), int'(st));
         chk("stall_D", int'(stall_D), int'(st));
         chk("flush_E", int'(flush_E), int'(st));
         if (!st) begin
            chk("fwd_rs_D", int'(fwd_rs_D), m_fwd_d(int'(rs_D)));
            chk("fwd_rt_D", int'(fwd_rt_D), m_fwd_d(int'(rt_D)));
         end
         chk("fwd_rs_E", int'(fwd_rs_E), m_fwd_e(sl_e.rs));
         chk("fwd_rt_E", int'(fwd_rt_E), m_fwd_e(sl_e.rt));
         chk("md_busy", int'(md_busy), int'(m_busy()));
`ifdef HAZARD_PERF_CNT_EN
         chk("stall_cnt", int'(stall_cnt), int'(m_stall_cnt));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop();
      rs_D = 0; rt_D = 0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
      wreg_D = 0; regwrite_D = 0; tnew_D = 0;
      md_use_D = 0; md_start_E = 0; md_is_div_E = 0;
   endtask

   task automatic set_d(input int rs, input int trs, input int rt, input int trt,
                        input int wr, input int rw, input int tn);
      rs_D = 5'(rs); tuse_rs_D = 2'(trs); rt_D = 5'(rt); tuse_rt_D = 2'(trt);
      wreg_D = 5'(wr); regwrite_D = 1'(rw); tnew_D = 2'(tn);
      md_use_D = 0; md_start_E = 0; md_is_div_E = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_nop();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      set_nop();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk_en = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_stall", int'(stall_D), 0);
      chk("rst_fwd_rs_E", int'(fwd_rs_E), 0);
      chk("rst_md_busy", int'(md_busy), 0);
`ifdef HAZARD_PERF_CNT_EN
      chk("rst_stall_cnt", int'(stall_cnt), 0);
`endif

      // load-use: lw $8 then addu $9,$8,$1
      tick();
      set_d(29, 1, 0, 3, 8, 1, 2);
      @(negedge clk);
      chk("lu_lw_nostall", int'(stall_D), 0);
      tick();
      set_d(8, 1, 1, 1, 9, 1, 1);
      @(negedge clk);
      chk("lu_stall_D", int'(stall_D), 1);
      chk("lu_stall_F", int'(stall_F), 1);
      chk("lu_flush_E", int'(flush_E), 1);
      tick();
      @(negedge clk);
      chk("lu_release", int'(stall_D), 0);
      chk("lu_fwd_rs_D", int'(fwd_rs_D), 0);
      tick();
      set_nop();
      @(negedge clk);
      chk("lu_fwd_rs_E", int'(fwd_rs_E), 2);
`ifdef HAZARD_PERF_CNT_EN
      chk("lu_stall_cnt", int'(stall_cnt), 1);
`endif

      // jal $31 then jr $31
      tick();
      do_reset();
      set_d(0, 3, 0, 3, 31, 1, 0);
      tick();
      set_d(31, 0, 0, 3, 0, 0, 0);
      @(negedge clk);
      chk("jr_stall", int'(stall_D), 0);
      chk("jr_fwd_rs_D", int'(fwd_rs_D), 1);

      // M and W both write $5: M wins
      tick();
      do_reset();
      set_d(0, 3, 0, 3, 5, 1, 0);
      tick();
      set_d(0, 3, 0, 3, 5, 1, 1);
      tick();
      set_d(0, 3, 5, 1, 0, 0, 0);
      tick();
      set_nop();
      @(negedge clk);
      chk("prio_fwd_rt_E", int'(fwd_rt_E), 1);

      // $0 never matches
      tick();
      do_reset();
      set_d(0, 3, 0, 3, 0, 1, 2);
      tick();
      set_d(0, 0, 0, 0, 7, 1, 1);
      @(negedge clk);
      chk("r0_stall", int'(stall_D), 0);
      chk("r0_fwd_rs_D", int'(fwd_rs_D), 0);
      tick();
      set_nop();
      @(negedge clk);
      chk("r0_fwd_rs_E", int'(fwd_rs_E), 0);
      chk("r0_stall2", int'(stall_D), 0);

      // div busy window: 11 cycles, then released
      tick();
      do_reset();
      md_start_E = 1; md_is_div_E = 1; md_use_D = 1;
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         chk($sformatf("div_busy_%0d", k), int'(md_busy), 1);
         chk($sformatf("div_stall_%0d", k), int'(stall_D), 1);
         tick();
         md_start_E = 0;
      end
      @(negedge clk);
      chk("div_busy_end", int'(md_busy), 0);
      chk("div_stall_end", int'(stall_D), 0);

      // mult busy window: 6 cycles
      tick();
      do_reset();
      md_start_E = 1; md_is_div_E = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("mult_busy_%0d", k), int'(md_busy), 1);
         tick();
         md_start_E = 0;
      end
      @(negedge clk);
      chk("mult_busy_end", int'(md_busy), 0);

      // reset at t+3 of a divide
      tick();
      do_reset();
      set_d(0, 3, 0, 3, 8, 1, 0);
      md_start_E = 1; md_is_div_E = 1;
      tick();
      md_start_E = 0; md_use_D = 1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_d(8, 0, 8, 0, 0, 0, 0);
      @(negedge clk);
      chk("rd_md_busy", int'(md_busy), 0);
      chk("rd_stall", int'(stall_D), 0);
      chk("rd_fwd_rs_D", int'(fwd_rs_D), 0);
      chk("rd_fwd_rt_D", int'(fwd_rt_D), 0);
      chk("rd_fwd_rs_E", int'(fwd_rs_E), 0);
      chk("rd_fwd_rt_E", int'(fwd_rt_E), 0);
`ifdef HAZARD_PERF_CNT_EN
      chk("rd_stall_cnt", int'(stall_cnt), 0);
`endif

      // randomized traffic on a small register set to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         tick();
         reset       = ($urandom_range(0, 199) == 0);
         rs_D        = 5'($urandom_range(0, 3));
         rt_D        = 5'($urandom_range(0, 3));
         tuse_rs_D   = 2'($urandom_range(0, 3));
         tuse_rt_D   = 2'($urandom_range(0, 3));
         wreg_D      = 5'($urandom_range(0, 3));
         regwrite_D  = 1'($urandom_range(0, 1));
         tnew_D      = 2'($urandom_range(0, 2));
         md_use_D    = ($urandom_range(0, 3) == 0);
         md_start_E  = ($urandom_range(0, 7) == 0);
         md_is_div_E = 1'($urandom_range(0, 1));
      end
      tick();
      reset = 1'b0;
      set_nop();
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and forwarding controller for the five-stage MIPS pipeline (F/D/E/M/W). It tracks which register each in-flight instruction writes and when that result becomes available, using an internal E→M→W shadow of the write-destination fields. From this it decides stalls, E-stage bubbles and bypass-mux selects for the D and E stages. It also sequences the multi-cycle multiply/divide unit's busy window so that HI/LO consumers wait for the result.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rs_D, rt_D  in  5 each  source registers of the instruction in D
- tuse_rs_D, tuse_rt_D  in  2 each  cycles until the operand is needed; 3 = operand not used
- wreg_D  in  5  destination register of the D instruction (0 = none)
- regwrite_D  in  1  D instruction writes the GPR file
- tnew_D  in  2  cycles from E entry until the result exists (0..2)
- md_use_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- md_start_E  in  1  E instruction starts the MDU this cycle
- md_is_div_E  in  1  the started operation is a divide
- stall_F, stall_D  out  1  hold PC and the D register
- flush_E  out  1  load a bubble into the E register
- fwd_rs_D, fwd_rt_D  out  2  0 = regfile, 1 = E result, 2 = M result
- fwd_rs_E, fwd_rt_E  out  2  0 = E register, 1 = M result, 2 = W result
- md_busy  out  1  MDU result not yet available
- stall_cnt  out  32  stall cycle count (only with HAZARD_PERF_CNT_EN)

## Operation
- **Shadow pipeline.** Registers {rs,rt,wreg,regwrite,tnew}_E, {wreg,regwrite,tnew}_M and {wreg,regwrite}_W.
  - Each cycle: E←D, M←E, W←M.
  - tnew_M ← (tnew_E==0) ? 0 : tnew_E−1.
  - On stall, the E shadow loads zeros (a bubble); M and W still advance.
- **Match rule.** A stage matches source register r when r≠0, regwrite is set for that stage, and wreg==r.
- **Stall.** Asserted when, for rs_D or rt_D:
  - the E stage matches and tuse < tnew_E, or
  - the M stage matches and tuse < tnew_M, or
  - md_use_D && md_busy.
- stall drives stall_F = stall_D = flush_E = 1 in the same cycle (combinational).
- **D forwarding.** Forward from E when E matches and tnew_E==0; otherwise from M when M matches and tnew_M==0; otherwise 0. E has priority over M. W is covered by the write-first regfile.
- **E forwarding.** Uses rs_E/rt_E. Forward from M when M matches and tnew_M==0; otherwise from W when W matches; otherwise 0. M has priority over W.
- **MDU tracking.**
  - md_start_E loads the counter with DIV_CYCLES if md_is_div_E, else MULT_CYCLES.
  - Otherwise the counter decrements while nonzero.
  - md_busy = md_start_E || (counter≠0).
  - A start while the counter is nonzero reloads the counter.

## Timing
- Reset values: all shadow registers 0, counter 0, and therefore every output 0 (stall_cnt 0).
- Hazard and forwarding outputs are combinational from inputs and the shadow state; no added latency.
- mult started in cycle t: md_busy is high during cycles t..t+5 and low from t+6.
- div started in cycle t: md_busy is high during cycles t..t+10.
- Reset mid-operation clears the counter and the shadow registers. The next cycle sees no hazards.
- Stall and forward on the same register in the same cycle: stall wins. The forward select value is don't-care while stalled.
- Register 0 never matches and never stalls.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - the stall_cnt port exists;
  - it increments by 1 in every cycle in which stall is 1, wraps at 2^32, and is cleared by reset.
- HAZARD_PERF_CNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `pipe_pkg`:
  - FWD_* encodings (FWD_RF/FWD_E/FWD_M/FWD_W);
  - TUSE_NONE=3;
  - TNEW widths;
  - MULT_CYCLES/DIV_CYCLES defaults.
- Sub-module `mdu_busy_tracker`: the counter, the load/decrement logic and md_busy.

## Test plan
- **D-stage load-use stall.** lw $8 in E (tnew_D=2 at entry) followed by addu $9,$8,$1 (tuse_rs=1) → stall=1 for 1 cycle, then fwd_rs_D=0 and fwd_rs_E=2 when the addu reaches E.
- **E-to-D forward.** jal writes $31 with tnew=0, then jr $31 (tuse=0) → no stall, fwd_rs_D=1.
- **Priority and $0.**
  - M and W both write $5 → fwd_rt_E=1 (M wins).
  - Destination $0 with rs_E=0 → fwd_rs_E=0, stall=0.
- **MDU busy window.** div start then mflo in D → md_busy for 11 cycles, stall_D=1 throughout, released in cycle t+11.
- **Reset mid-div.** Assert reset at t+3 → md_busy=0 and all forwards 0 on the next cycle; stall_cnt=0 (macro build).
